// File: rtl/rx_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkt_pkg
// Description : Shared types for the packet receive controller: FSM state
//               encoding and error-cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkt_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SYNC     = 4'd1,
    SYNC_CHK = 4'd2,
    RECV     = 4'd3,
    WRITE    = 4'd4,
    CHK      = 4'd5,
    EOP1     = 4'd6,
    ERR      = 4'd7,
    ERR_WAIT = 4'd8,
    ERR_EOP  = 4'd9
  } state_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_BAD_SYNC  = 3'd1;
  localparam logic [2:0] ERR_EARLY_EOP = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG  = 3'd4;
  localparam logic [2:0] ERR_TOO_SHORT = 3'd5;

endpackage
`default_nettype wire

// File: rtl/rx_pkt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkt_ctrl_if
// Description : Bundle between the line-side detectors / FIFO and the receive
//               controller. The master drives line events, the slave (the
//               controller) drives FIFO control and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_pkt_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 7
);
  logic              d_edge;
  logic              eop;
  logic              shift_enable;
  logic [DATA_W-1:0] rcv_data;
  logic              byte_received;
  logic              fifo_full;
  logic              rcving;
  logic              w_enable;
  logic              flush;
  logic              r_error;
  logic [2:0]        err_code;
  logic              pkt_done;
  logic [CNT_W-1:0]  byte_count;

  modport master (
    output d_edge, eop, shift_enable, rcv_data, byte_received, fifo_full,
    input  rcving, w_enable, flush, r_error, err_code, pkt_done, byte_count
  );

  modport slave (
    input  d_edge, eop, shift_enable, rcv_data, byte_received, fifo_full,
    output rcving, w_enable, flush, r_error, err_code, pkt_done, byte_count
  );
endinterface
`default_nettype wire

// File: rtl/rx_byte_counter.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_counter
// Description : Payload word counter with synchronous clear; saturates at
//               MAX_BYTES so it can never wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_counter #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  // Count written words; clear wins over increment, stop at the ceiling.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkt_ctrl
// Description : Receive control unit. Checks the sync word, gates FIFO writes
//               per payload word, enforces min/max length, detects FIFO
//               overflow and reports an encoded error cause.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_pkt_ctrl
  import rx_pkt_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = 8'h80,
  parameter int                MIN_BYTES    = 1,
  parameter int                MAX_BYTES    = 64,
  parameter int                CNT_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  rx_pkt_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state;
  state_t           state_nxt;
  logic             pkt_start;
  logic             code_load;
  logic [2:0]       code_val;
  logic             sticky_set;
  logic             done_set;
  logic             err_sticky;
  logic [2:0]       err_cause;
  logic             done_pulse;
  logic [CNT_W-1:0] byte_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the side effects that load the status registers.
  always_comb begin
    state_nxt  = state;
    pkt_start  = 1'b0;
    code_load  = 1'b0;
    code_val   = ERR_NONE;
    sticky_set = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_edge) begin
          pkt_start = 1'b1;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (bus.byte_received) state_nxt = SYNC_CHK;
      end
      SYNC_CHK: begin
        if (bus.rcv_data == SYNC_PATTERN) begin
          state_nxt = RECV;
        end else begin
          state_nxt = ERR;
          code_load = 1'b1;
          code_val  = ERR_BAD_SYNC;
        end
      end
      RECV: begin
        // Line-level EOP outranks any word event in the same cycle.
        if (bus.eop && bus.shift_enable) begin
          state_nxt = ERR;
          code_load = 1'b1;
          code_val  = ERR_EARLY_EOP;
        end else if (bus.byte_received && bus.fifo_full) begin
          state_nxt = ERR;
          code_load = 1'b1;
          code_val  = ERR_OVERFLOW;
        end else if (bus.byte_received && (byte_count == MAX_CNT)) begin
          state_nxt = ERR;
          code_load = 1'b1;
          code_val  = ERR_TOO_LONG;
        end else if (bus.byte_received) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = CHK;
      end
      CHK: begin
        if (bus.shift_enable && bus.eop) begin
          state_nxt = EOP1;
        end else if (bus.shift_enable) begin
          state_nxt = RECV;
        end
      end
      EOP1: begin
        if (!bus.eop && bus.shift_enable) begin
          state_nxt = IDLE;
          // A short packet is reported but not flushed; the host drops it.
          if (byte_count < MIN_CNT) begin
            code_load  = 1'b1;
            code_val   = ERR_TOO_SHORT;
            sticky_set = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ERR: begin
        sticky_set = 1'b1;
        state_nxt  = ERR_WAIT;
      end
      ERR_WAIT: begin
        if (bus.eop && bus.shift_enable) state_nxt = ERR_EOP;
      end
      ERR_EOP: begin
        if (!bus.eop && bus.shift_enable) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sticky error flag, error cause and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cause  <= ERR_NONE;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= done_set;
      if (pkt_start) begin
        err_sticky <= 1'b0;
        err_cause  <= ERR_NONE;
      end else begin
        if (sticky_set) err_sticky <= 1'b1;
        if (code_load)  err_cause  <= code_val;
      end
    end
  end

  rx_byte_counter #(
    .MAX_BYTES (MAX_BYTES),
    .CNT_W     (CNT_W)
  ) u_byte_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (pkt_start),
    .inc   (state == WRITE),
    .count (byte_count)
  );

  assign bus.rcving     = (state != IDLE);
  assign bus.w_enable   = (state == WRITE);
  assign bus.flush      = (state == ERR);
  assign bus.r_error    = err_sticky || (state inside {ERR, ERR_WAIT, ERR_EOP});
  assign bus.err_code   = err_cause;
  assign bus.pkt_done   = done_pulse;
  assign bus.byte_count = byte_count;

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_pkt_ctrl
// Description : Directed bench for rx_pkt_ctrl. Two instances share one
//               stimulus stream: dut_a uses default limits, dut_b uses
//               MIN_BYTES=2 / MAX_BYTES=4 for the length-limit cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_pkt_ctrl;

  logic       clk;
  logic       rst;
  logic       d_edge, eop, shift_enable, byte_received, fifo_full;
  logic [7:0] rcv_data;

  int checks = 0;
  int errors = 0;
  int wa, fa, da, wb, fb, db;

  rx_pkt_ctrl_if #(.DATA_W(8), .CNT_W(7)) ifa ();
  rx_pkt_ctrl_if #(.DATA_W(8), .CNT_W(3)) ifb ();

  assign ifa.d_edge        = d_edge;
  assign ifa.eop           = eop;
  assign ifa.shift_enable  = shift_enable;
  assign ifa.rcv_data      = rcv_data;
  assign ifa.byte_received = byte_received;
  assign ifa.fifo_full     = fifo_full;
  assign ifb.d_edge        = d_edge;
  assign ifb.eop           = eop;
  assign ifb.shift_enable  = shift_enable;
  assign ifb.rcv_data      = rcv_data;
  assign ifb.byte_received = byte_received;
  assign ifb.fifo_full     = fifo_full;

  rx_pkt_ctrl #(.DATA_W(8), .SYNC_PATTERN(8'h80), .MIN_BYTES(1), .MAX_BYTES(64), .CNT_W(7))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rx_pkt_ctrl #(.DATA_W(8), .SYNC_PATTERN(8'h80), .MIN_BYTES(2), .MAX_BYTES(4), .CNT_W(3))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs {de,eop,se,br,full,data} and expected dut_a outputs
  // {rcving,w_enable,flush,r_error,err_code,pkt_done,byte_count}.
  typedef struct packed {
    logic       de, eop, se, br, full;
    logic [7:0] data;
    logic       rc, we, fl, re;
    logic [2:0] code;
    logic       done;
    logic [6:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic de, input logic e, input logic se,
                              input logic br, input logic full, input logic [7:0] data,
                              input logic rc, input logic we, input logic fl,
                              input logic re, input logic [2:0] code,
                              input logic done, input logic [6:0] cnt);
    vec_t v;
    v.de = de; v.eop = e; v.se = se; v.br = br; v.full = full; v.data = data;
    v.rc = rc; v.we = we; v.fl = fl; v.re = re; v.code = code;
    v.done = done; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  function automatic logic [14:0] outs_a();
    return {ifa.rcving, ifa.w_enable, ifa.flush, ifa.r_error,
            ifa.err_code, ifa.pkt_done, ifa.byte_count};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, wait for the edge, settle, tally pulses.
  task automatic cyc(input logic de, input logic e, input logic se,
                     input logic br, input logic full, input logic [7:0] data);
    d_edge = de; eop = e; shift_enable = se;
    byte_received = br; fifo_full = full; rcv_data = data;
    @(posedge clk);
    #1;
    wa += int'(ifa.w_enable); fa += int'(ifa.flush); da += int'(ifa.pkt_done);
    wb += int'(ifb.w_enable); fb += int'(ifb.flush); db += int'(ifb.pkt_done);
  endtask

  task automatic clr_cnt();
    wa = 0; fa = 0; da = 0; wb = 0; fb = 0; db = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    clr_cnt();
  endtask

  // IDLE -> SYNC -> SYNC_CHK -> RECV with a good sync word.
  task automatic start_pkt();
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'h80);
    cyc(0, 0, 0, 0, 0, 8'h80);
  endtask

  // RECV -> WRITE -> CHK.
  task automatic word(input logic [7:0] data);
    cyc(0, 0, 0, 1, 0, data);
    cyc(0, 0, 0, 0, 0, data);
  endtask

  // CHK -> RECV.
  task automatic adv();
    cyc(0, 0, 1, 0, 0, 8'h00);
  endtask

  logic [14:0] got;
  logic [14:0] exp;

  initial begin
    clr_cnt();
    d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0; fifo_full = 0;
    rcv_data = 8'h00;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("reset_outs_a", int'(outs_a()), 0);
    chk("reset_rcving_b", int'(ifb.rcving), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 8'h00);

    // Good packet: sync, 11/22/33 (one CHK hold), EOP.
    add(1,0,0,0,0,8'h00, 1,0,0,0,3'd0,0,7'd0);
    add(0,0,0,0,0,8'h00, 1,0,0,0,3'd0,0,7'd0);
    add(0,0,0,1,0,8'h80, 1,0,0,0,3'd0,0,7'd0);
    add(0,0,0,0,0,8'h80, 1,0,0,0,3'd0,0,7'd0);
    add(0,0,0,1,0,8'h11, 1,1,0,0,3'd0,0,7'd0);
    add(0,0,0,0,0,8'h11, 1,0,0,0,3'd0,0,7'd1);
    add(0,0,1,0,0,8'h11, 1,0,0,0,3'd0,0,7'd1);
    add(0,0,0,1,0,8'h22, 1,1,0,0,3'd0,0,7'd1);
    add(0,0,0,0,0,8'h22, 1,0,0,0,3'd0,0,7'd2);
    add(0,0,0,0,0,8'h22, 1,0,0,0,3'd0,0,7'd2);
    add(0,0,1,0,0,8'h22, 1,0,0,0,3'd0,0,7'd2);
    add(0,0,0,1,0,8'h33, 1,1,0,0,3'd0,0,7'd2);
    add(0,0,0,0,0,8'h33, 1,0,0,0,3'd0,0,7'd3);
    add(0,1,1,0,0,8'h33, 1,0,0,0,3'd0,0,7'd3);
    add(0,1,1,0,0,8'h33, 1,0,0,0,3'd0,0,7'd3);
    add(0,0,1,0,0,8'h33, 0,0,0,0,3'd0,1,7'd3);
    add(0,0,0,0,0,8'h00, 0,0,0,0,3'd0,0,7'd3);
    // Bad sync word 0x81: flush once, sticky error until next d_edge.
    add(1,0,0,0,0,8'h00, 1,0,0,0,3'd0,0,7'd0);
    add(0,0,0,1,0,8'h81, 1,0,0,0,3'd0,0,7'd0);
    add(0,0,0,0,0,8'h81, 1,0,1,1,3'd1,0,7'd0);
    add(0,0,0,0,0,8'h81, 1,0,0,1,3'd1,0,7'd0);
    add(0,0,0,1,1,8'h80, 1,0,0,1,3'd1,0,7'd0);
    add(0,1,1,0,0,8'h00, 1,0,0,1,3'd1,0,7'd0);
    add(0,1,0,0,0,8'h00, 1,0,0,1,3'd1,0,7'd0);
    add(0,0,1,0,0,8'h00, 0,0,0,1,3'd1,0,7'd0);
    add(0,0,0,0,0,8'h00, 0,0,0,1,3'd1,0,7'd0);
    add(1,0,0,0,0,8'h00, 1,0,0,0,3'd0,0,7'd0);
    add(1,0,0,0,0,8'h00, 1,0,0,0,3'd0,0,7'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].de, tbl[i].eop, tbl[i].se, tbl[i].br, tbl[i].full, tbl[i].data);
      got = outs_a();
      exp = {tbl[i].rc, tbl[i].we, tbl[i].fl, tbl[i].re,
             tbl[i].code, tbl[i].done, tbl[i].cnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got %b, expected %b", i, got, exp);
      end
    end

    // Reset mid-RECV: abandon packet, no flush.
    cyc(0, 0, 0, 1, 0, 8'h80);
    cyc(0, 0, 0, 0, 0, 8'h80);
    word(8'h11);
    adv();
    chk("pre_rst_count", int'(ifa.byte_count), 1);
    clr_cnt();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("rst_outs_a", int'(outs_a()), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    chk("rst_no_flush", fa, 0);

    // Overflow: fifo_full on the second payload word.
    do_reset();
    start_pkt();
    word(8'h11);
    adv();
    cyc(0, 0, 0, 1, 1, 8'h22);
    chk("ovf_code", int'(ifa.err_code), 3);
    chk("ovf_flush", int'(ifa.flush), 1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h33);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("ovf_writes", wa, 1);
    chk("ovf_flushes", fa, 1);
    chk("ovf_done", da, 0);
    chk("ovf_rerr_idle", int'(ifa.r_error), 1);

    // Early EOP before any payload, then a clean restart.
    do_reset();
    start_pkt();
    cyc(0, 1, 1, 0, 0, 8'h00);
    chk("eeop_code", int'(ifa.err_code), 2);
    chk("eeop_flush", int'(ifa.flush), 1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("eeop_rerr_idle", int'(ifa.r_error), 1);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("restart_code", int'(ifa.err_code), 0);
    chk("restart_rerr", int'(ifa.r_error), 0);
    cyc(0, 0, 0, 1, 0, 8'h80);
    cyc(0, 0, 0, 0, 0, 8'h80);
    word(8'h44);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("restart_done", da, 1);
    chk("restart_count", int'(ifa.byte_count), 1);

    // Too long on dut_b (MAX_BYTES=4): fifth word errors after four writes.
    do_reset();
    start_pkt();
    for (int k = 0; k < 4; k++) begin
      word(8'(8'h50 + k));
      adv();
    end
    cyc(0, 0, 0, 1, 0, 8'h55);
    chk("long_code", int'(ifb.err_code), 4);
    chk("long_flush", int'(ifb.flush), 1);
    chk("long_writes", wb, 4);
    chk("long_count", int'(ifb.byte_count), 4);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("long_done", db, 0);

    // Too short on dut_b (MIN_BYTES=2); dut_a (MIN_BYTES=1) accepts it.
    do_reset();
    start_pkt();
    word(8'h66);
    cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("short_code", int'(ifb.err_code), 5);
    chk("short_rerr", int'(ifb.r_error), 1);
    chk("short_rcving", int'(ifb.rcving), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("short_done", db, 0);
    chk("short_flush", fb, 0);
    chk("short_count", int'(ifb.byte_count), 1);
    chk("min1_done_a", da, 1);
    chk("min1_rerr_a", int'(ifa.r_error), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
